// File: rtl/vc_sink_arb_pkg.sv
// vc_sink_arb_pkg: shared types for the virtual-channel sink arbiter.
//   vc_sink_arb_state_t : run-control FSM states (IDLE, RUN, DONE, TOUT).
package vc_sink_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } vc_sink_arb_state_t;

endpackage

// File: rtl/vc_sink_arb_rr_pick.sv
// vc_sink_arb_rr_pick: combinational round-robin picker.
//   req_val   : per-requester valid
//   ptr       : index where the search starts (wraps modulo p_num_reqs)
//   grant     : one-hot of the selected requester (0 when none valid)
//   grant_idx : index of the selected requester
//   any_val   : at least one requester is valid
module vc_sink_arb_rr_pick #(
  parameter int unsigned p_num_reqs = 4
) (
  input  logic [p_num_reqs-1:0]         req_val,
  input  logic [$clog2(p_num_reqs)-1:0] ptr,
  output logic [p_num_reqs-1:0]         grant,
  output logic [$clog2(p_num_reqs)-1:0] grant_idx,
  output logic                          any_val
);

  localparam int unsigned IW = $clog2(p_num_reqs);

  // Rotate so bit k of rot is requester (ptr+k) mod p_num_reqs; the first
  // set bit of rot is then the round-robin winner.
  logic [p_num_reqs-1:0] rot;
  int unsigned           pick_sum;

  assign rot = p_num_reqs'({req_val, req_val} >> ptr);

  always_comb begin
    any_val   = 1'b0;
    pick_sum  = 0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      if (!any_val && rot[k]) begin
        any_val  = 1'b1;
        pick_sum = 32'(ptr) + k;
        if (pick_sum >= p_num_reqs) pick_sum = pick_sum - p_num_reqs;
      end
    end
    grant_idx = pick_sum[IW-1:0];
    for (int unsigned j = 0; j < p_num_reqs; j++) begin
      grant[j] = any_val && (pick_sum == j);
    end
  end

endmodule

// File: rtl/vc_sink_arb.sv
// vc_sink_arb: round-robin merge of p_num_reqs requesters into one test sink
// through a one-entry output buffer, with run-control FSM.
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle pulse, IDLE -> RUN
//   req_val/req_rdy     : per-requester handshake; req_msg is flattened
//   sink_val/sink_rdy   : handshake to the shared sink; sink_msg, grant_id
//   sink_done           : sink has seen all expected messages
//   busy, done, timeout : state == RUN / DONE / TOUT
// Optional watchdog: define VC_SINK_ARB_TIMEOUT_EN to enable the RUN->TOUT
// watchdog; without it TOUT is unreachable and timeout is 0.
module vc_sink_arb
  import vc_sink_arb_pkg::*;
#(
  parameter int unsigned p_msg_nbits      = 32,
  parameter int unsigned p_num_reqs       = 4,
  parameter int unsigned p_timeout_cycles = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [p_num_reqs-1:0]             req_val,
  output logic [p_num_reqs-1:0]             req_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] req_msg,
  output logic                              sink_val,
  input  logic                              sink_rdy,
  output logic [p_msg_nbits-1:0]            sink_msg,
  input  logic                              sink_done,
  output logic [$clog2(p_num_reqs)-1:0]     grant_id,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout
);

  localparam int unsigned   IW       = $clog2(p_num_reqs);
  localparam logic [IW-1:0] LAST_IDX = IW'(p_num_reqs - 1);

  vc_sink_arb_state_t     state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   buf_full_q, buf_full_d;
  logic [p_msg_nbits-1:0] buf_msg_q, buf_msg_d;
  logic [IW-1:0]          buf_id_q, buf_id_d;

  logic [p_num_reqs-1:0]  grant;
  logic [IW-1:0]          pick_idx;
  logic                   any_val;
  logic [p_msg_nbits-1:0] pick_msg;
  logic                   in_run, accept_ok, req_fire, sink_fire, wd_expire;

  vc_sink_arb_rr_pick #(
    .p_num_reqs (p_num_reqs)
  ) u_pick (
    .req_val   (req_val),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (pick_idx),
    .any_val   (any_val)
  );

  always_comb begin
    pick_msg = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (grant[i]) pick_msg = req_msg[i*p_msg_nbits +: p_msg_nbits];
    end
  end

  assign in_run    = (state_q == ST_RUN);
  // A full buffer can still accept when the sink drains it this cycle.
  assign accept_ok = in_run && (!buf_full_q || sink_rdy);
  assign req_rdy   = accept_ok ? grant : '0;
  assign req_fire  = accept_ok && any_val;
  assign sink_val  = buf_full_q && (state_q != ST_TOUT);
  assign sink_fire = sink_val && sink_rdy;
  // Gated so every output reads 0 after reset despite buf_msg not being reset.
  assign sink_msg  = sink_val ? buf_msg_q : '0;
  assign grant_id  = buf_id_q;
  assign busy      = in_run;
  assign done      = (state_q == ST_DONE);

`ifdef VC_SINK_ARB_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(p_timeout_cycles + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(p_timeout_cycles - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (in_run) wd_d = sink_fire ? '0 : wd_q + WD_W'(1);
  end

  // Leave RUN on the edge where the count reaches p_timeout_cycles.
  assign wd_expire = in_run && !sink_fire && (wd_q == WD_LAST);
  assign timeout   = (state_q == ST_TOUT);

  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^p_timeout_cycles;
  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (wd_expire)                     state_d = ST_TOUT;
        else if (sink_done && !buf_full_q) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_msg_d  = buf_msg_q;
    buf_id_d   = buf_id_q;
    ptr_d      = ptr_q;
    if (req_fire) begin
      buf_full_d = 1'b1;
      buf_msg_d  = pick_msg;
      buf_id_d   = pick_idx;
      ptr_d      = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
    end else if (sink_fire) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      buf_full_q <= 1'b0;
      buf_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf_full_q <= buf_full_d;
      buf_id_q   <= buf_id_d;
    end
    buf_msg_q <= buf_msg_d;
  end

endmodule

// File: tb/tb_vc_sink_arb.sv
// tb_vc_sink_arb: self-checking bench for vc_sink_arb (4 requesters, 32-bit
// messages, watchdog limit 10). Inputs change on the falling edge; outputs
// are sampled 1 ns later and compared against a behavioural model that
// advances on every rising edge.
module tb_vc_sink_arb;

  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 10;
`ifdef VC_SINK_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, start, sink_rdy, sink_done;
  logic [N-1:0]   req_val, req_rdy;
  logic [N*W-1:0] req_msg;
  logic           sink_val, busy, done, timeout;
  logic [W-1:0]   sink_msg;
  logic [1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_sink_arb #(
    .p_msg_nbits      (W),
    .p_num_reqs       (N),
    .p_timeout_cycles (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .sink_val  (sink_val),
    .sink_rdy  (sink_rdy),
    .sink_msg  (sink_msg),
    .sink_done (sink_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  // Reference model: m_st 0=idle 1=run 2=done 3=timed out.
  int           m_st, m_ptr, m_id, m_wd;
  bit           m_full;
  logic [W-1:0] m_msg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (req_val[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g = pick();
    if (m_st == 1 && (!m_full || sink_rdy) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  function automatic bit exp_sval();
    return m_full && (m_st != 3);
  endfunction

  task automatic check_model();
    chk("m.req_rdy", 32'(req_rdy), 32'(exp_rdy()));
    chk("m.sink_val", 32'(sink_val), 32'(exp_sval()));
    if (exp_sval()) chk("m.sink_msg", sink_msg, m_msg);
    chk("m.grant_id", 32'(grant_id), 32'(m_id));
    chk("m.busy", 32'(busy), 32'(m_st == 1));
    chk("m.done", 32'(done), 32'(m_st == 2));
    chk("m.timeout", 32'(timeout), 32'(m_st == 3));
  endtask

  task automatic model_clock();
    int g, nst;
    bit rf, sf;
    if (reset) begin
      m_st = 0; m_ptr = 0; m_full = 0; m_id = 0; m_wd = 0;
      return;
    end
    g   = pick();
    rf  = (m_st == 1) && (!m_full || sink_rdy) && (g >= 0);
    sf  = exp_sval() && sink_rdy;
    nst = m_st;
    if (m_st == 0 && start) nst = 1;
    else if (m_st == 1) begin
      if (TO_EN && !sf && (m_wd + 1 == T)) nst = 3;
      else if (sink_done && !m_full)       nst = 2;
    end
    if (m_st == 1) m_wd = sf ? 0 : m_wd + 1;
    if (rf) begin
      m_full = 1; m_msg = req_msg[g*W +: W]; m_id = g; m_ptr = (g + 1) % N;
    end else if (sf) begin
      m_full = 0;
    end
    m_st = nst;
  endtask

  // Caller sets inputs after a falling edge; tick checks, crosses one rising
  // edge and returns at the next falling edge.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; req_val = '0; sink_rdy = 1'b0; sink_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req_rdy"}, 32'(req_rdy), 32'd0);
    chk({tag, ".sink_val"}, 32'(sink_val), 32'd0);
    chk({tag, ".sink_msg"}, sink_msg, 32'd0);
    chk({tag, ".grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'd0);
  endtask

  typedef struct {
    logic         start;
    logic [N-1:0] rv;
    logic         srdy;
    logic         sdone;
    logic [N-1:0] e_rdy;
    logic         e_sval;
    logic [1:0]   e_gid;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) req_msg[i*W +: W] = 32'h100 + 32'(i);
    m_st = 0; m_ptr = 0; m_full = 0; m_id = 0; m_wd = 0; m_msg = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1 check_zero("reset");

    // Round-robin with everyone requesting and the sink always ready.
    //            start rv     srdy sdone e_rdy  sval gid busy done
    tbl[0] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};
    for (int r = 0; r < 10; r++) begin
      start = tbl[r].start; req_val = tbl[r].rv;
      sink_rdy = tbl[r].srdy; sink_done = tbl[r].sdone;
      #1;
      chk($sformatf("vec%0d.req_rdy", r), 32'(req_rdy), 32'(tbl[r].e_rdy));
      chk($sformatf("vec%0d.sink_val", r), 32'(sink_val), 32'(tbl[r].e_sval));
      if (tbl[r].e_sval) begin
        chk($sformatf("vec%0d.grant_id", r), 32'(grant_id), 32'(tbl[r].e_gid));
        chk($sformatf("vec%0d.sink_msg", r), sink_msg, 32'h100 + 32'(tbl[r].e_gid));
      end
      chk($sformatf("vec%0d.busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("vec%0d.done", r), 32'(done), 32'(tbl[r].e_done));
      tick();
    end

    // Single requester held off by the sink for five cycles.
    do_reset();
    req_msg[2*W +: W] = 32'hA5;
    start = 1'b1;
    tick();
    start = 1'b0; req_val = 4'b0100; sink_rdy = 1'b0;
    #1 chk("stall.first_rdy", 32'(req_rdy), 32'b0100);
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall.sink_val", 32'(sink_val), 32'd1);
      chk("stall.sink_msg", sink_msg, 32'hA5);
      chk("stall.req_rdy", 32'(req_rdy), 32'd0);
      tick();
    end
    sink_rdy = 1'b1;
    #1;
    chk("release.req_rdy", 32'(req_rdy), 32'b0100);
    chk("release.sink_val", 32'(sink_val), 32'd1);
    tick();
    #1;
    chk("refill.sink_val", 32'(sink_val), 32'd1);
    chk("refill.sink_msg", sink_msg, 32'hA5);

    // Reset in RUN while the buffer is full.
    reset = 1'b1; sink_rdy = 1'b0; req_val = '0;
    tick();
    reset = 1'b0;
    #1 check_zero("midrun_reset");

    // Pointer wrap: ptr=3 with only requester 1 valid.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0; req_val = 4'b0100; sink_rdy = 1'b1;
    tick();
    req_val = 4'b0010;
    #1 chk("wrap.req_rdy", 32'(req_rdy), 32'b0010);
    tick();
    req_val = 4'hF;
    #1;
    chk("wrap.next_ptr", 32'(req_rdy), 32'b0100);
    chk("wrap.grant_id", 32'(grant_id), 32'd1);
    tick();

    // Watchdog stimulus: start, then the sink never accepts.
    do_reset();
    start = 1'b1; req_val = 4'hF;
    tick();
    start = 1'b0;
    #1 chk("wd.busy_rise", 32'(busy), 32'd1);
`ifdef VC_SINK_ARB_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      tick();
      #1;
      chk($sformatf("wd.timeout_k%0d", k), 32'(timeout), 32'(k >= T));
      if (k >= T) chk($sformatf("wd.sink_val_k%0d", k), 32'(sink_val), 32'd0);
    end
`else
    for (int k = 1; k <= 200; k++) begin
      tick();
      #1;
      chk("nowd.timeout", 32'(timeout), 32'd0);
      chk("nowd.busy", 32'(busy), 32'd1);
    end
`endif

    // Randomised runs against the model.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      start = 1'b1;
      tick();
      for (int c = 0; c < 200; c++) begin
        reset     = ($urandom_range(0, 150) == 0);
        start     = ($urandom_range(0, 20) == 0);
        req_val   = N'($urandom);
        sink_rdy  = ($urandom_range(0, 3) != 0);
        sink_done = ($urandom_range(0, 40) == 0);
        req_msg   = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_sink_arb.md
VC_SINK_ARB -- requirements
Module: vc_sink_arb

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 32: message width in bits.
REQ-002 SHALL have parameter p_num_reqs, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter p_timeout_cycles, default 1000: watchdog limit in cycles.
REQ-004 SHALL have port clk  in  1  clock; reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port req_val  in  p_num_reqs  per-requester valid.
REQ-008 SHALL have port req_rdy  out  p_num_reqs  per-requester ready.
REQ-009 SHALL have port req_msg  in  p_num_reqs*p_msg_nbits  flattened messages; requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
REQ-010 SHALL have port sink_val  out  1  valid to the shared test sink.
REQ-011 SHALL have port sink_rdy  in  1  ready from the test sink.
REQ-012 SHALL have port sink_msg  out  p_msg_nbits  message to the test sink.
REQ-013 SHALL have port sink_done  in  1  the test sink reports that all expected messages have been received.
REQ-014 SHALL have port grant_id  out  $clog2(p_num_reqs)  source index of the message on sink_msg.
REQ-015 SHALL have ports busy, done, timeout  out  1 each  status flags.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN, DONE and TOUT.
- IDLE->RUN on start.
- RUN->DONE when sink_done=1 and the buffer is empty.
- RUN->TOUT when the watchdog expires.
- DONE and TOUT are terminal until reset.
REQ-017 SHALL hold a one-entry output buffer (buf_full, buf_msg, buf_id); sink_val=buf_full; sink_msg=buf_msg; grant_id=buf_id.
REQ-018 SHALL, in RUN, grant the first requester with req_val=1, searching from round-robin pointer ptr upward and wrapping modulo p_num_reqs.
REQ-019 SHALL assert req_rdy only for the granted requester, and only when state=RUN and (buf_full=0 or sink_rdy=1).
REQ-020 SHALL load the buffer on a requester handshake (req_val&req_rdy); the message appears on sink_msg the next cycle (latency 1).
REQ-021 SHALL update ptr to (granted index+1) mod p_num_reqs after each accepted transfer; ptr SHALL be unchanged otherwise.
REQ-022 SHALL, when a sink transfer and a requester transfer occur in the same cycle, reload the buffer so it stays full with no bubble.
REQ-023 SHALL clear buf_full on a sink transfer with no simultaneous refill.
REQ-024 SHALL hold buf_msg and buf_id stable while sink_val=1 and sink_rdy=0.
REQ-025 SHALL hold req_rdy=0 in IDLE, DONE and TOUT, and SHALL force sink_val=0 in TOUT.
REQ-026 SHALL keep the RUN->DONE condition unmet while sink_done=1 and buf_full=1, so the block stays in RUN and the watchdog decides.
REQ-027 SHALL drive busy=(state==RUN), done=(state==DONE) and timeout=(state==TOUT).

Reset
REQ-028 SHALL, on reset, set state=IDLE, ptr=0, buf_full=0, buf_id=0 and watchdog=0; every output SHALL be 0 the cycle after reset asserts, including when reset is asserted in mid-run.
REQ-029 SHALL leave buf_msg contents unspecified after reset; sink_msg SHALL be don't-care while sink_val=0.

Configuration
REQ-030 SHALL compile the watchdog in only when macro VC_SINK_ARB_TIMEOUT_EN is defined.
- With the macro: a counter of width $clog2(p_timeout_cycles+1) increments each RUN cycle without a sink transfer and clears to 0 on a sink transfer. Reaching p_timeout_cycles causes RUN->TOUT.
- Without the macro: no counter exists, TOUT is unreachable, and timeout is tied to 0.

Structure
REQ-031 SHALL place the state enum typedef (vc_sink_arb_state_t) and the state encodings in package vc_sink_arb_pkg.
REQ-032 SHALL use one combinational sub-module, vc_sink_arb_rr_pick (inputs req_val and ptr; outputs grant one-hot, grant index and any_val).

Verification
REQ-033 SHALL cover: p_num_reqs=4, all req_val=1, sink_rdy=1 after start -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles, starting one cycle after the first handshake.
REQ-034 SHALL cover: only req_val[2]=1, req_msg slot 2=0xA5, sink_rdy held 0 for 5 cycles -> sink_val=1, sink_msg=0xA5 stable, all req_rdy=0; on sink_rdy=1 the transfer completes and req_rdy[2]=1 in the same cycle.
REQ-035 SHALL cover: ptr=3 with only req_val[1]=1 -> requester 1 granted after wrap; next ptr=2.
REQ-036 SHALL cover: with VC_SINK_ARB_TIMEOUT_EN and p_timeout_cycles=10, start then no sink transfers -> timeout=1 exactly 10 cycles after busy rises, and sink_val=0 from then on.
REQ-037 SHALL cover: sink_done=1 with buffer empty -> done=1 next cycle; in a separate run, reset asserted in RUN with buf_full=1 -> sink_val=0 and busy=0 the next cycle.
REQ-038 SHALL cover: without VC_SINK_ARB_TIMEOUT_EN, the REQ-036 stimulus -> timeout stays 0 and busy stays 1 for 200 cycles.
